// File: rtl/fp_div_arb_pkg.sv
// Shared types and default sizing for the FP divider-sharing arbiter.
package fp_div_arb_pkg;

  localparam int unsigned DEF_WIDTH       = 24;
  localparam int unsigned DEF_NREQ        = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_id
);

  logic w_found;

  always_comb begin
    o_gnt   = '0;
    o_id    = '0;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned idx;
      idx = (32'(i_ptr) + 32'(k)) % NREQ;
      if (!w_found && i_req[IDW'(idx)]) begin
        w_found           = 1'b1;
        o_gnt[IDW'(idx)]  = 1'b1;
        o_id              = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fp_div_share_arb.sv
// Shares one sequential divider among NREQ requesters with round-robin arbitration.
// Optional watchdog on the divider done handshake: define FP_DIV_ARB_TIMEOUT_EN.
module fp_div_share_arb
  import fp_div_arb_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned NREQ        = DEF_NREQ,
  parameter int unsigned IDW         = $clog2(NREQ),
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_q,
  output logic [WIDTH-1:0]      rsp_f,
  output logic                  rsp_dbz,
`ifdef FP_DIV_ARB_TIMEOUT_EN
  output logic                  rsp_timeout,
`endif
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_a,
  output logic [WIDTH-1:0]      div_b,
  input  logic                  div_done,
  input  logic                  div_dbz,
  input  logic [WIDTH-1:0]      div_q,
  input  logic [WIDTH-1:0]      div_f
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_gid;
  logic              r_div_start;
  logic [WIDTH-1:0]  r_div_a;
  logic [WIDTH-1:0]  r_div_b;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [WIDTH-1:0]  r_rsp_q;
  logic [WIDTH-1:0]  r_rsp_f;
  logic              r_rsp_dbz;

  logic [NREQ-1:0]   w_gnt;
  logic [IDW-1:0]    w_gid;
  logic              w_accept;
  logic              w_capture;
  logic              w_timeout;
  logic              w_to_hit;
  logic [WIDTH-1:0]  w_a_arr [NREQ];
  logic [WIDTH-1:0]  w_b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign w_b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_id  (w_gid)
  );

  // Ready is gated by reset so every output reads 0 while arst is held.
  assign req_ready = (r_state == ST_IDLE && !arst) ? w_gnt : '0;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (div_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RELEASE;
        end else if (w_to_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RELEASE;
        end
      end
      // done lags the divider's return to idle; a start issued before it falls sees a stale result
      ST_RELEASE: begin
        if (!div_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_ptr       <= IDW'(NREQ - 1);
      r_gid       <= '0;
      r_div_start <= 1'b0;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_rsp_valid <= '0;
      r_rsp_q     <= '0;
      r_rsp_f     <= '0;
      r_rsp_dbz   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_accept) begin
        r_div_a     <= w_a_arr[w_gid];
        r_div_b     <= w_b_arr[w_gid];
        r_gid       <= w_gid;
        r_ptr       <= w_gid;
        r_div_start <= 1'b1;
      end
      if (w_capture) begin
        r_rsp_q     <= div_q;
        r_rsp_f     <= div_f;
        r_rsp_dbz   <= div_dbz;
        r_div_start <= 1'b0;
        r_rsp_valid <= NREQ'(1) << r_gid;
      end
      if (w_timeout) begin
        r_rsp_q     <= '0;
        r_rsp_f     <= '0;
        r_rsp_dbz   <= 1'b0;
        r_div_start <= 1'b0;
        r_rsp_valid <= NREQ'(1) << r_gid;
      end
    end
  end

`ifdef FP_DIV_ARB_TIMEOUT_EN
  localparam int unsigned CNTW = $clog2(TIMEOUT_CYC + 1);

  logic [CNTW-1:0] r_cnt;
  logic            r_rsp_timeout;

  // Counts ISSUE cycles; fires on the TIMEOUT_CYC-th edge after the accept.
  assign w_to_hit = (r_state == ST_ISSUE) && (r_cnt == CNTW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt         <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (r_state != ST_ISSUE) r_cnt <= '0;
      else                     r_cnt <= r_cnt + CNTW'(1);
      if (w_capture) r_rsp_timeout <= 1'b0;
      if (w_timeout) r_rsp_timeout <= 1'b1;
    end
  end

  assign rsp_timeout = r_rsp_timeout;
`else
  logic w_unused_timeout;

  assign w_to_hit         = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
`endif

  assign rsp_valid = r_rsp_valid;
  assign rsp_q     = r_rsp_q;
  assign rsp_f     = r_rsp_f;
  assign rsp_dbz   = r_rsp_dbz;
  assign div_start = r_div_start;
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;

endmodule

// File: tb/tb_fp_div_share_arb.sv
// Directed bench for fp_div_share_arb with a behavioural divider whose done lags start release.
module tb_fp_div_share_arb;

  localparam int unsigned W   = 24;
  localparam int unsigned N   = 4;
  localparam int unsigned IW  = 2;
  localparam int          LAT = 5;
  localparam int          TO  = 16;

  logic            clk = 1'b0;
  logic            arst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N-1:0]    rsp_valid;
  logic [W-1:0]    rsp_q;
  logic [W-1:0]    rsp_f;
  logic            rsp_dbz;
  logic            div_start;
  logic [W-1:0]    div_a;
  logic [W-1:0]    div_b;
  logic            div_done;
  logic            div_dbz;
  logic [W-1:0]    div_q;
  logic [W-1:0]    div_f;
`ifdef FP_DIV_ARB_TIMEOUT_EN
  logic            rsp_timeout;
`endif

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  int tot = 0;
  int bad = 0;
  int cyc = 0;
  int m_viol = 0;
  bit hang = 1'b0;

  int g_id_q[$];
  int g_cyc_q[$];

  typedef struct {
    logic [N-1:0] v;
    logic [W-1:0] q;
    logic [W-1:0] f;
    logic         dbz;
    logic         to;
    int           cyc;
  } rsp_t;
  rsp_t rsp_log[$];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a[g*W +: W] = op_a[g];
    assign req_b[g*W +: W] = op_b[g];
  end

  fp_div_share_arb #(
    .WIDTH       (W),
    .NREQ        (N),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_q       (rsp_q),
    .rsp_f       (rsp_f),
    .rsp_dbz     (rsp_dbz),
`ifdef FP_DIV_ARB_TIMEOUT_EN
    .rsp_timeout (rsp_timeout),
`endif
    .div_start   (div_start),
    .div_a       (div_a),
    .div_b       (div_b),
    .div_done    (div_done),
    .div_dbz     (div_dbz),
    .div_q       (div_q),
    .div_f       (div_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: done rises LAT cycles after start is seen, falls one cycle after start drops.
  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE, M_LAG} m_e;
  m_e          m_st;
  int          m_cnt;
  logic [W-1:0] m_a, m_b;
  logic        m_prev_start;

  function automatic logic [W-1:0] frac_of(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] num;
    num = {W'(a % b), W'(0)};
    return W'(num / {W'(0), b});
  endfunction

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_st <= M_IDLE; m_cnt <= 0; div_done <= 1'b0; div_dbz <= 1'b0;
      div_q <= '0; div_f <= '0; m_a <= '0; m_b <= '0; m_prev_start <= 1'b0;
    end else begin
      m_prev_start <= div_start;
      if (div_start && !m_prev_start && div_done) m_viol <= m_viol + 1;
      case (m_st)
        M_IDLE: if (div_start) begin m_a <= div_a; m_b <= div_b; m_cnt <= 0; m_st <= M_BUSY; end
        M_BUSY: begin
          if (!div_start) m_st <= M_IDLE;
          else if (!hang && m_cnt == LAT - 1) begin
            div_done <= 1'b1;
            m_st     <= M_DONE;
            if (m_b == '0) begin div_dbz <= 1'b1; div_q <= '0; div_f <= '0; end
            else begin div_dbz <= 1'b0; div_q <= m_a / m_b; div_f <= frac_of(m_a, m_b); end
          end else m_cnt <= m_cnt + 1;
        end
        M_DONE: if (!div_start) m_st <= M_LAG;
        M_LAG: begin
          if (div_start) m_viol <= m_viol + 1;
          div_done <= 1'b0;
          m_st     <= M_IDLE;
        end
        default: m_st <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!arst && |rsp_valid) begin
      rsp_t r;
      r.v = rsp_valid; r.q = rsp_q; r.f = rsp_f; r.dbz = rsp_dbz; r.cyc = cyc;
`ifdef FP_DIV_ARB_TIMEOUT_EN
      r.to = rsp_timeout;
`else
      r.to = 1'b0;
`endif
      rsp_log.push_back(r);
    end
  end

  task automatic set_op(input logic [IW-1:0] id, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[id] = a;
    op_b[id] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b1; req_valid = '0;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    g_id_q.delete(); g_cyc_q.delete(); rsp_log.delete();
  endtask

  // Raises mask, records each grant, drops each granted bit after acceptance unless hold is set.
  task automatic run_set(input logic [N-1:0] mask, input bit hold, input int n, output bit ok);
    int got;
    logic [N-1:0] clr;
    @(negedge clk);
    req_valid = mask; got = 0; ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      #1;
      clr = '0;
      if (|req_ready) begin
        got++;
        for (int j = 0; j < N; j++) if (req_ready[j]) g_id_q.push_back(j);
        g_cyc_q.push_back(cyc);
        if (!hold) clr = req_ready;
      end
      @(negedge clk);
      req_valid = req_valid & ~clr;
      if (got == n) begin ok = 1'b1; req_valid = '0; end
    end
    if (!ok) req_valid = '0;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    for (int i = 0; i < 400 && rsp_log.size() < n; i++) begin
      @(negedge clk); #1;
    end
    ok = (rsp_log.size() >= n);
  endtask

  task automatic test_reset();
    arst = 1'b1; req_valid = '0;
    repeat (3) @(negedge clk);
    tot++; if ({req_ready, rsp_valid, rsp_q, rsp_f, rsp_dbz, div_start, div_a, div_b} !== '0) begin
      bad++; $display("FAIL reset_outputs got div_start=%b rsp_valid=%b req_ready=%b", div_start, rsp_valid, req_ready);
    end
    arst = 1'b0;
    @(negedge clk);
    tot++; if ({div_start, rsp_valid} !== '0) begin
      bad++; $display("FAIL reset_release_idle got div_start=%b rsp_valid=%b exp 0", div_start, rsp_valid);
    end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    set_op(2'd0, 24'd10, 24'd4);
    run_set(4'b0001, 1'b0, 1, ok);
    tot++; if (!ok || g_id_q.size() != 1 || g_id_q[0] != 0) begin bad++; $display("FAIL basic_grant got ok=%0d n=%0d exp req0", ok, g_id_q.size()); end
    wait_rsp(1, ok);
    tot++; if (!ok) begin bad++; $display("FAIL basic_rsp_timeout got none exp 1 rsp"); end
    else begin
      tot++; if (rsp_log[0].v !== 4'b0001) begin bad++; $display("FAIL basic_valid got %b exp 0001", rsp_log[0].v); end
      tot++; if (rsp_log[0].q !== 24'd2) begin bad++; $display("FAIL basic_q got %0d exp 2", rsp_log[0].q); end
      tot++; if (rsp_log[0].f !== 24'h800000) begin bad++; $display("FAIL basic_f got %h exp 800000", rsp_log[0].f); end
      tot++; if (rsp_log[0].dbz !== 1'b0) begin bad++; $display("FAIL basic_dbz got %b exp 0", rsp_log[0].dbz); end
      tot++; if (rsp_log[0].cyc - g_cyc_q[0] - 1 != LAT + 2) begin
        bad++; $display("FAIL basic_latency got %0d exp %0d", rsp_log[0].cyc - g_cyc_q[0] - 1, LAT + 2);
      end
    end
    repeat (10) @(negedge clk);
    tot++; if (rsp_log.size() != 1) begin bad++; $display("FAIL basic_single_pulse got %0d pulses exp 1", rsp_log.size()); end
    tot++; if (rsp_q !== 24'd2 || rsp_valid !== '0) begin bad++; $display("FAIL basic_hold got q=%0d v=%b exp q=2 v=0", rsp_q, rsp_valid); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_reset();
    set_op(2'd0, 24'd6, 24'd3);
    set_op(2'd2, 24'd1, 24'd3);
    run_set(4'b0101, 1'b0, 2, ok);
    tot++; if (!ok || g_id_q.size() != 2 || g_id_q[0] != 0 || g_id_q[1] != 2) begin
      bad++; $display("FAIL simul_order got ok=%0d n=%0d exp grants 0,2", ok, g_id_q.size());
    end
    wait_rsp(2, ok);
    tot++; if (!ok) begin bad++; $display("FAIL simul_rsp_timeout got %0d exp 2", rsp_log.size()); end
    else begin
      tot++; if ({rsp_log[0].v, rsp_log[0].q, rsp_log[0].f} !== {4'b0001, 24'd2, 24'd0}) begin
        bad++; $display("FAIL simul_rsp0 got v=%b q=%0d f=%h exp v=0001 q=2 f=0", rsp_log[0].v, rsp_log[0].q, rsp_log[0].f);
      end
      tot++; if ({rsp_log[1].v, rsp_log[1].q, rsp_log[1].f, rsp_log[1].dbz} !== {4'b0100, 24'd0, 24'h555555, 1'b0}) begin
        bad++; $display("FAIL simul_rsp2 got v=%b q=%0d f=%h exp v=0100 q=0 f=555555", rsp_log[1].v, rsp_log[1].q, rsp_log[1].f);
      end
    end
  endtask

  // No reset: pointer sits at 2 from the previous test, so 3 wins before 1.
  task automatic test_back_to_back();
    bit ok;
    g_id_q.delete(); g_cyc_q.delete(); rsp_log.delete();
    set_op(2'd1, 24'd5, 24'd0);
    set_op(2'd3, 24'd1, 24'd4);
    run_set(4'b1010, 1'b0, 2, ok);
    tot++; if (!ok || g_id_q.size() != 2 || g_id_q[0] != 3 || g_id_q[1] != 1) begin
      bad++; $display("FAIL b2b_order got ok=%0d n=%0d exp grants 3,1", ok, g_id_q.size());
    end
    wait_rsp(2, ok);
    tot++; if (!ok) begin bad++; $display("FAIL b2b_rsp_timeout got %0d exp 2", rsp_log.size()); end
    else begin
      tot++; if ({rsp_log[0].v, rsp_log[0].q, rsp_log[0].f, rsp_log[0].dbz} !== {4'b1000, 24'd0, 24'h400000, 1'b0}) begin
        bad++; $display("FAIL b2b_rsp3 got v=%b q=%0d f=%h dbz=%b exp v=1000 q=0 f=400000 dbz=0", rsp_log[0].v, rsp_log[0].q, rsp_log[0].f, rsp_log[0].dbz);
      end
      tot++; if ({rsp_log[1].v, rsp_log[1].q, rsp_log[1].f, rsp_log[1].dbz} !== {4'b0010, 24'd0, 24'd0, 1'b1}) begin
        bad++; $display("FAIL b2b_dbz got v=%b q=%0d f=%h dbz=%b exp v=0010 q=0 f=0 dbz=1", rsp_log[1].v, rsp_log[1].q, rsp_log[1].f, rsp_log[1].dbz);
      end
    end
    tot++; if (m_viol != 0) begin bad++; $display("FAIL b2b_start_while_done got %0d violations exp 0", m_viol); end
  endtask

  task automatic test_all_four();
    bit ok;
    int exp_id [5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] exp_q [N] = '{24'd0, 24'd1, 24'd1, 24'd2};
    logic [W-1:0] exp_f [N] = '{24'h800000, 24'd0, 24'h800000, 24'd0};
    do_reset();
    for (int i = 0; i < N; i++) set_op(IW'(i), W'(i + 1), 24'd2);
    run_set(4'b1111, 1'b1, 5, ok);
    wait_rsp(5, ok);
    repeat (15) @(negedge clk);
    tot++; if (g_id_q.size() != 5 || rsp_log.size() != 5) begin
      bad++; $display("FAIL all4_count got grants=%0d rsps=%0d exp 5/5", g_id_q.size(), rsp_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tot++; if (g_id_q[i] != exp_id[i]) begin bad++; $display("FAIL all4_grant%0d got %0d exp %0d", i, g_id_q[i], exp_id[i]); end
        tot++; if (rsp_log[i].v !== N'(1) << exp_id[i] || rsp_log[i].q !== exp_q[exp_id[i]] || rsp_log[i].f !== exp_f[exp_id[i]]) begin
          bad++; $display("FAIL all4_rsp%0d got v=%b q=%0d f=%h exp req%0d q=%0d f=%h", i, rsp_log[i].v, rsp_log[i].q, rsp_log[i].f, exp_id[i], exp_q[exp_id[i]], exp_f[exp_id[i]]);
        end
      end
    end
  endtask

  task automatic test_drop();
    bit ok;
    do_reset();
    set_op(2'd0, 24'd8, 24'd2);
    set_op(2'd3, 24'd3, 24'd1);
    run_set(4'b0001, 1'b0, 1, ok);
    req_valid = 4'b1000;
    repeat (2) @(negedge clk);
    req_valid = '0;
    wait_rsp(1, ok);
    repeat (20) @(negedge clk);
    tot++; if (rsp_log.size() != 1 || div_start !== 1'b0) begin
      bad++; $display("FAIL drop_not_granted got rsps=%0d div_start=%b exp 1/0", rsp_log.size(), div_start);
    end else begin
      tot++; if ({rsp_log[0].v, rsp_log[0].q} !== {4'b0001, 24'd4}) begin
        bad++; $display("FAIL drop_rsp got v=%b q=%0d exp v=0001 q=4", rsp_log[0].v, rsp_log[0].q);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    set_op(2'd2, 24'd7, 24'd2);
    run_set(4'b0100, 1'b0, 1, ok);
    repeat (2) @(negedge clk);
    tot++; if (div_start !== 1'b1) begin bad++; $display("FAIL midrst_busy got div_start=%b exp 1", div_start); end
    arst = 1'b1;
    #1;
    tot++; if ({req_ready, rsp_valid, rsp_q, rsp_f, rsp_dbz, div_start, div_a, div_b} !== '0) begin
      bad++; $display("FAIL midrst_outputs got div_start=%b div_a=%h div_b=%h exp all 0", div_start, div_a, div_b);
    end
    @(negedge clk);
    arst = 1'b0;
    repeat (20) @(negedge clk);
    tot++; if (rsp_log.size() != 0) begin bad++; $display("FAIL midrst_no_rsp got %0d rsps exp 0", rsp_log.size()); end
    set_op(2'd1, 24'd9, 24'd2);
    run_set(4'b0010, 1'b0, 1, ok);
    wait_rsp(1, ok);
    tot++; if (!ok || {rsp_log[0].v, rsp_log[0].q, rsp_log[0].f, rsp_log[0].dbz} !== {4'b0010, 24'd4, 24'h800000, 1'b0}) begin
      bad++; $display("FAIL midrst_recover got n=%0d exp v=0010 q=4 f=800000", rsp_log.size());
    end
  endtask

`ifdef FP_DIV_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    do_reset();
    hang = 1'b1;
    set_op(2'd1, 24'd10, 24'd4);
    run_set(4'b0010, 1'b0, 1, ok);
    wait_rsp(1, ok);
    tot++; if (!ok) begin bad++; $display("FAIL to_no_rsp got none exp 1"); end
    else begin
      tot++; if ({rsp_log[0].v, rsp_log[0].to, rsp_log[0].q, rsp_log[0].f, rsp_log[0].dbz} !== {4'b0010, 1'b1, 24'd0, 24'd0, 1'b0}) begin
        bad++; $display("FAIL to_rsp got v=%b to=%b q=%0d exp v=0010 to=1 q=0", rsp_log[0].v, rsp_log[0].to, rsp_log[0].q);
      end
      tot++; if (rsp_log[0].cyc - g_cyc_q[0] - 1 != TO) begin
        bad++; $display("FAIL to_latency got %0d exp %0d", rsp_log[0].cyc - g_cyc_q[0] - 1, TO);
      end
    end
    hang = 1'b0;
    repeat (3) @(negedge clk);
    set_op(2'd2, 24'd10, 24'd4);
    run_set(4'b0100, 1'b0, 1, ok);
    wait_rsp(2, ok);
    tot++; if (!ok || {rsp_log[1].v, rsp_log[1].to, rsp_log[1].q} !== {4'b0100, 1'b0, 24'd2}) begin
      bad++; $display("FAIL to_recover got n=%0d exp v=0100 to=0 q=2", rsp_log.size());
    end
  endtask
`endif

  initial begin
    arst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
    test_reset();
    test_basic();
    test_simultaneous();
    test_back_to_back();
    test_all_four();
    test_drop();
    test_reset_mid();
`ifdef FP_DIV_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/fp_div_share_arb.md
Name: fp_div_share_arb

Overview:
Round-robin controller that shares one sequential divider instance among NREQ requesters.
- Accepts operand pairs over a per-requester valid/ready handshake.
- Sequences the divider's level-held start / done handshake, including the release phase.
- Returns the integer quotient, fraction and div-by-zero flag to the requester that issued the operation.
- Sits between the FP mult/div front-ends and the single shared divider datapath.

Parameters:
WIDTH, 24, operand/quotient/fraction width; must match the divider.
NREQ, 4, number of requesters (2..8).
IDW, $clog2(NREQ), requester id width (derived).
TIMEOUT_CYC, 64, watchdog limit in cycles; used only with FP_DIV_ARB_TIMEOUT_EN.

Ports:
clk  in  1  clock, rising edge.
arst  in  1  reset, asynchronous, active-high.
req_valid  in  NREQ  per-requester operation request.
req_ready  out  NREQ  one-hot accept, combinational from state and req_valid.
req_a  in  NREQ*WIDTH  dividends; requester i occupies slice [i*WIDTH +: WIDTH].
req_b  in  NREQ*WIDTH  divisors, same packing.
rsp_valid  out  NREQ  one-hot, single-cycle result pulse.
rsp_q  out  WIDTH  integer quotient.
rsp_f  out  WIDTH  fraction bits.
rsp_dbz  out  1  divide-by-zero flag.
div_start  out  1  divider start; registered and held high until div_done.
div_a  out  WIDTH  divider dividend; registered and stable while busy.
div_b  out  WIDTH  divider divisor; registered and stable while busy.
div_done  in  1  divider done (level).
div_dbz  in  1  divider div_by_zero.
div_q  in  WIDTH  divider q.
div_f  in  WIDTH  divider f.

Behaviour:
Reset:
- All outputs 0; state IDLE; rr pointer = NREQ-1, so requester 0 has first priority.
- Reset mid-operation aborts the operation silently; no rsp_valid is issued.

States:
- IDLE
  - Winner = first set req_valid bit searching upward from pointer+1, modulo NREQ.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0.
  - On the accepting edge: latch div_a/div_b from the winner's slices, store grant id, pointer <= winner, div_start <= 1, go to ISSUE.
  - No req_valid bits set: remain in IDLE.
- ISSUE
  - div_start held at 1.
  - On the first cycle div_done=1: capture div_q/div_f/div_dbz into the rsp registers, div_start <= 0, go to RELEASE.
  - On the next edge, rsp_valid[grant] pulses for exactly 1 cycle.
- RELEASE
  - div_start=0; wait until div_done=0.
  - The divider's done lags its return to idle by one cycle. Issuing a new start before done falls would capture a stale result.
  - When div_done=0, go to IDLE.

Rules:
- Only one operation is in flight at a time. req_ready is 0 for all requesters outside IDLE.
- rsp_q/rsp_f/rsp_dbz hold their values until the next capture.
- Latency from req accept to rsp_valid = divider latency + 2 cycles.
- Requesters must keep req_a/req_b stable while req_valid is high; after acceptance the operands are don't-care.
- Results are forwarded unmodified: b=0 gives rsp_dbz=1, q=0, f=0.
- A requester that drops req_valid before being accepted loses nothing and is not granted.
- Simultaneous requests are resolved strictly by the round-robin order; no starvation, worst-case wait = NREQ-1 operations.

Optional Feature:
FP_DIV_ARB_TIMEOUT_EN
- Defined:
  - Adds output rsp_timeout (1 bit) and a cycle counter that runs in ISSUE.
  - If TIMEOUT_CYC cycles elapse without div_done: rsp_valid[grant] pulses with rsp_timeout=1 and rsp_q/rsp_f/rsp_dbz=0; div_start <= 0; go to RELEASE.
  - rsp_timeout=0 on every normal response.
- Undefined: no counter and no port; ISSUE waits indefinitely for div_done.

Decomposition:
- Package fp_div_arb_pkg: state enum (IDLE, ISSUE, RELEASE), default WIDTH/NREQ constants, TIMEOUT_CYC default.
- Sub-module rr_arbiter(NREQ): combinational inputs req vector and pointer; outputs one-hot grant and binary id. Reusable by the multiplier-sharing controller.

Test Plan:
- WIDTH=24, req0 a=10, b=4 -> rsp_valid[0] pulse, rsp_q=2, rsp_f=0x800000, rsp_dbz=0.
- req2 a=1, b=3 -> rsp_valid[2], rsp_q=0, rsp_f=0x555555. req1 b=0 -> rsp_dbz=1, q=0, f=0.
- req0 and req2 asserted in the same cycle after reset -> grants 0 then 2. All four requesters held valid -> grant order 0,1,2,3,0, each with exactly one rsp pulse.
- Back-to-back operations -> no second div_start while div_done is still high. Check with a divider model holding done 1 cycle past start fall.
- arst pulsed in ISSUE -> all outputs 0 next cycle, no rsp_valid. A new request afterward completes correctly.
- FP_DIV_ARB_TIMEOUT_EN with a stub whose done never rises -> rsp_timeout=1 on rsp_valid[grant] exactly TIMEOUT_CYC cycles after the accept, then back to IDLE.
